pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, retire, redirects,
// misaligned-target traps and a retired-instruction counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [31:0] instret,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] trap_pc_q;
    logic [31:0] instret_q;
    logic        trap_q;
    logic        imem_req_q;
    logic        instr_valid_q;

    logic        retire;
    logic [31:0] target;
    logic        misaligned;

    assign retire = (state_q == S_EXEC) && !stall;

    // Jump outranks branch; JALR clears the low bit before alignment check.
    always_comb begin
        target = pc_q + 32'd4;
        if (jump) begin
            target = jalr ? {jump_target[31:1], 1'b0} : jump_target;
        end else if (branch_taken) begin
            target = branch_target;
        end
    end

    assign misaligned = (target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (imem_ack) state_d = S_EXEC;
            S_EXEC: begin
                if (retire) begin
                    state_d = halt_req ? S_HALT : S_FETCH;
                    pc_d    = misaligned ? TRAP_VECTOR : target;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            trap_q        <= 1'b0;
            trap_pc_q     <= 32'h0;
            instret_q     <= 32'h0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= (state_d == S_FETCH);
            instr_valid_q <= (state_d == S_EXEC);
            trap_q        <= retire && misaligned;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
                if (misaligned) trap_pc_q <= pc_q;
            end
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign trap        = trap_q;
    assign trap_pc     = trap_pc_q;
    assign instret     = instret_q;
    assign state       = state_q;

endmodule
